// File: rtl/rdlvl_seq_pkg.sv
// Shared types and constants for the read-training sequencer.
// State encoding, fail-phase codes and the default settle length.
package rdlvl_seq_pkg;

   localparam int unsigned DEF_SETTLE_CYCLES = 16;

   localparam logic [1:0] FP_CFG   = 2'b00;
   localparam logic [1:0] FP_GATE  = 2'b01;
   localparam logic [1:0] FP_RDLVL = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEL_RANK,
      ST_SETTLE,
      ST_GATE,
      ST_GATE_GAP,
      ST_RDLVL,
      ST_RDLVL_GAP,
      ST_NEXT_RANK,
      ST_DONE,
      ST_FAIL
   } state_t;

endpackage

// File: rtl/rdlvl_seq_lane_tracker.sv
// Per-lane sticky done/error collection for one training phase.
// The _c outputs fold in the current cycle's sample so a late response still completes.
module rdlvl_seq_lane_tracker
#(
   parameter int unsigned LANES = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             sample,
   input  logic [LANES-1:0] mask,
   input  logic [LANES-1:0] resp,
   input  logic [LANES-1:0] err,
   output logic [LANES-1:0] done_c,
   output logic [LANES-1:0] err_c,
   output logic             all_done_c
);

   logic [LANES-1:0] done_q;
   logic [LANES-1:0] err_q;
   logic [LANES-1:0] hit;

   assign hit        = sample ? (resp & mask) : '0;
   assign done_c     = done_q | hit;
   assign err_c      = err_q | (hit & err);
   assign all_done_c = &(done_c | ~mask);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         done_q <= '0;
         err_q  <= '0;
      end else begin
         done_q <= done_c;
         err_q  <= err_c;
      end
   end

endmodule

// File: rtl/rdlvl_seq_ctrl.sv
// Read-training sequencer: gate then read-levelling per enabled rank, with timeout and status.
// Define RDLVL_SEQ_RETRY_EN to retry a rank on phase errors up to MAX_RETRIES times.
module rdlvl_seq_ctrl
   import rdlvl_seq_pkg::*;
#(
   parameter int unsigned IOG_DQS_LANES = 9,
   parameter int unsigned TIMEOUT_W     = 20,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic                     SCLK,
   input  logic                     reset,
   input  logic                     train_start,
   input  logic [1:0]               rank_en,
   input  logic [IOG_DQS_LANES-1:0] lane_mask,
   input  logic [TIMEOUT_W-1:0]     timeout_limit,
   input  logic [IOG_DQS_LANES-1:0] dfi_rdlvl_resp_internal,
   input  logic [IOG_DQS_LANES-1:0] rd_training_error,
   output logic                     dfi_rdlvl_gate_en,
   output logic                     dfi_rdlvl_en,
   output logic                     dfi_rdlvl_cs_0_n,
   output logic                     dfi_rdlvl_cs_1_n,
   output logic                     train_busy,
   output logic                     train_done,
   output logic                     train_fail,
   output logic [IOG_DQS_LANES-1:0] fail_lanes,
   output logic [1:0]               fail_phase,
   output logic                     fail_timeout,
   output logic                     fail_rank,
   output logic [1:0]               retry_count
);

   localparam int unsigned LANES       = IOG_DQS_LANES;
   localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam int unsigned SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

`ifdef RDLVL_SEQ_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif

   state_t state, state_d;

   logic                 rank_q, rank_d;
   logic                 rank1_en_q, rank1_en_d;
   logic [LANES-1:0]     mask_q, mask_d;
   logic [SC_W-1:0]      settle_q, settle_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [1:0]           retry_d;
   logic [LANES-1:0]     fail_lanes_d;
   logic [1:0]           fail_phase_d;
   logic                 fail_timeout_d;
   logic                 fail_rank_d;

   logic gate_en_d, rdlvl_en_d, cs_0_n_d, cs_1_n_d;
   logic busy_d, done_d, fail_d;

   logic             in_phase_c;
   logic             rank_active_c;
   logic             tmo_hit_c;
   logic             settle_last_c;
   logic             retry_ok_c;
   logic [1:0]       phase_code_c;
   logic [LANES-1:0] lane_done_c;
   logic [LANES-1:0] lane_err_c;
   logic             all_done_c;

   assign in_phase_c    = (state == ST_GATE) || (state == ST_RDLVL);
   assign rank_active_c = state inside {ST_SEL_RANK, ST_SETTLE, ST_GATE, ST_GATE_GAP,
                                        ST_RDLVL, ST_RDLVL_GAP};
   assign tmo_hit_c     = in_phase_c && (timeout_limit != '0) && (tmo_q == timeout_limit);
   assign settle_last_c = (settle_q == SC_W'(SETTLE_LAST));
   assign retry_ok_c    = RETRY_ON && (32'(retry_count) < MAX_RETRIES);
   assign phase_code_c  = (state == ST_RDLVL) ? FP_RDLVL : FP_GATE;

   // Sticky bits live only for the duration of one phase.
   rdlvl_seq_lane_tracker #(
      .LANES (LANES)
   ) u_tracker (
      .clk        (SCLK),
      .reset      (reset),
      .clear      (!in_phase_c),
      .sample     (in_phase_c),
      .mask       (mask_q),
      .resp       (dfi_rdlvl_resp_internal),
      .err        (rd_training_error),
      .done_c     (lane_done_c),
      .err_c      (lane_err_c),
      .all_done_c (all_done_c)
   );

   always_ff @(posedge SCLK) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d        = state;
      rank_d         = rank_q;
      rank1_en_d     = rank1_en_q;
      mask_d         = mask_q;
      settle_d       = settle_q;
      tmo_d          = in_phase_c ? tmo_q + TIMEOUT_W'(1) : '0;
      retry_d        = retry_count;
      fail_lanes_d   = fail_lanes;
      fail_phase_d   = fail_phase;
      fail_timeout_d = fail_timeout;
      fail_rank_d    = fail_rank;

      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (train_start) begin
               rank1_en_d     = rank_en[1];
               mask_d         = lane_mask;
               rank_d         = ~rank_en[0];
               retry_d        = '0;
               fail_lanes_d   = '0;
               fail_phase_d   = FP_CFG;
               fail_timeout_d = 1'b0;
               fail_rank_d    = 1'b0;
               if ((rank_en == 2'b00) || (lane_mask == '0)) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_SEL_RANK;
               end
            end
         end

         ST_SEL_RANK: begin
            settle_d = '0;
            state_d  = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (settle_last_c) begin
               state_d = ST_GATE;
            end else begin
               settle_d = settle_q + SC_W'(1);
            end
         end

         // A response on the timeout-match cycle still counts as completion.
         ST_GATE, ST_RDLVL: begin
            if (all_done_c) begin
               if (lane_err_c != '0) begin
                  if (retry_ok_c) begin
                     retry_d = retry_count + 2'd1;
                     state_d = ST_SEL_RANK;
                  end else begin
                     state_d      = ST_FAIL;
                     fail_lanes_d = lane_err_c;
                     fail_phase_d = phase_code_c;
                     fail_rank_d  = rank_q;
                  end
               end else begin
                  settle_d = '0;
                  state_d  = (state == ST_GATE) ? ST_GATE_GAP : ST_RDLVL_GAP;
               end
            end else if (tmo_hit_c) begin
               state_d        = ST_FAIL;
               fail_timeout_d = 1'b1;
               fail_lanes_d   = mask_q & ~lane_done_c;
               fail_phase_d   = phase_code_c;
               fail_rank_d    = rank_q;
            end
         end

         // Wait for the settle time and for every response line to fall.
         ST_GATE_GAP, ST_RDLVL_GAP: begin
            if (!settle_last_c) begin
               settle_d = settle_q + SC_W'(1);
            end else if (dfi_rdlvl_resp_internal == '0) begin
               state_d = (state == ST_GATE_GAP) ? ST_RDLVL : ST_NEXT_RANK;
            end
         end

         ST_NEXT_RANK: begin
            if (!rank_q && rank1_en_q) begin
               rank_d  = 1'b1;
               retry_d = '0;
               state_d = ST_SEL_RANK;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      gate_en_d  = (state == ST_GATE) && !all_done_c && !tmo_hit_c;
      rdlvl_en_d = (state == ST_RDLVL) && !all_done_c && !tmo_hit_c;
      cs_0_n_d   = !(rank_active_c && !rank_q);
      cs_1_n_d   = !(rank_active_c && rank_q);
      busy_d     = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
      done_d     = (state == ST_DONE);
      fail_d     = (state == ST_FAIL);
   end

   always_ff @(posedge SCLK) begin
      if (reset) begin
         rank_q            <= 1'b0;
         rank1_en_q        <= 1'b0;
         mask_q            <= '0;
         settle_q          <= '0;
         tmo_q             <= '0;
         retry_count       <= '0;
         fail_lanes        <= '0;
         fail_phase        <= FP_CFG;
         fail_timeout      <= 1'b0;
         fail_rank         <= 1'b0;
         dfi_rdlvl_gate_en <= 1'b0;
         dfi_rdlvl_en      <= 1'b0;
         dfi_rdlvl_cs_0_n  <= 1'b1;
         dfi_rdlvl_cs_1_n  <= 1'b1;
         train_busy        <= 1'b0;
         train_done        <= 1'b0;
         train_fail        <= 1'b0;
      end else begin
         rank_q            <= rank_d;
         rank1_en_q        <= rank1_en_d;
         mask_q            <= mask_d;
         settle_q          <= settle_d;
         tmo_q             <= tmo_d;
         retry_count       <= retry_d;
         fail_lanes        <= fail_lanes_d;
         fail_phase        <= fail_phase_d;
         fail_timeout      <= fail_timeout_d;
         fail_rank         <= fail_rank_d;
         dfi_rdlvl_gate_en <= gate_en_d;
         dfi_rdlvl_en      <= rdlvl_en_d;
         dfi_rdlvl_cs_0_n  <= cs_0_n_d;
         dfi_rdlvl_cs_1_n  <= cs_1_n_d;
         train_busy        <= busy_d;
         train_done        <= done_d;
         train_fail        <= fail_d;
      end
   end

endmodule

// File: tb/tb_rdlvl_seq_ctrl.sv
// Directed bench for rdlvl_seq_ctrl with a small PHY responder driving per-lane resp/error.
// Expectations follow the RDLVL_SEQ_RETRY_EN setting of the build.
module tb_rdlvl_seq_ctrl;

   localparam int unsigned LANES = 9;
   localparam int unsigned TW    = 20;
   localparam int unsigned S     = 16;

   logic            SCLK = 1'b0;
   logic            reset;
   logic            train_start;
   logic [1:0]      rank_en;
   logic [8:0]      lane_mask;
   logic [TW-1:0]   timeout_limit;
   logic [8:0]      resp;
   logic [8:0]      err;
   logic            gate_en, rdlvl_en, cs_0_n, cs_1_n;
   logic            train_busy, train_done, train_fail;
   logic [8:0]      fail_lanes;
   logic [1:0]      fail_phase;
   logic            fail_timeout, fail_rank;
   logic [1:0]      retry_count;

   int checks = 0;
   int errors = 0;

   // Responder configuration
   int         delay [LANES];
   logic [8:0] silent;
   logic       err_on;
   logic [8:0] err_lanes;
   logic       err_in_rdlvl;
   logic       err_rank;
   int         plog [$];

   always #5 SCLK = ~SCLK;

   rdlvl_seq_ctrl #(
      .IOG_DQS_LANES (LANES),
      .TIMEOUT_W     (TW),
      .SETTLE_CYCLES (S),
      .MAX_RETRIES   (3)
   ) dut (
      .SCLK                    (SCLK),
      .reset                   (reset),
      .train_start             (train_start),
      .rank_en                 (rank_en),
      .lane_mask               (lane_mask),
      .timeout_limit           (timeout_limit),
      .dfi_rdlvl_resp_internal (resp),
      .rd_training_error       (err),
      .dfi_rdlvl_gate_en       (gate_en),
      .dfi_rdlvl_en            (rdlvl_en),
      .dfi_rdlvl_cs_0_n        (cs_0_n),
      .dfi_rdlvl_cs_1_n        (cs_1_n),
      .train_busy              (train_busy),
      .train_done              (train_done),
      .train_fail              (train_fail),
      .fail_lanes              (fail_lanes),
      .fail_phase              (fail_phase),
      .fail_timeout            (fail_timeout),
      .fail_rank               (fail_rank),
      .retry_count             (retry_count)
   );

   // PHY model: lane i answers delay[i] cycles after it first sees an enable high.
   initial begin : responder
      int   k;
      logic en_prev;
      k       = 0;
      en_prev = 1'b0;
      resp    = '0;
      err     = '0;
      forever begin
         @(posedge SCLK);
         #1;
         if (gate_en || rdlvl_en) begin
            if (!en_prev) begin
               k = 0;
               plog.push_back((cs_1_n == 1'b0 ? 2 : 0) + (rdlvl_en ? 1 : 0));
            end else begin
               k++;
            end
            for (int i = 0; i < LANES; i++) begin
               resp[i] = !silent[i] && (k >= delay[i]);
               err[i]  = resp[i] && err_on && err_lanes[i] && (rdlvl_en == err_in_rdlvl)
                         && ((!cs_1_n) == err_rank);
            end
         end else begin
            resp = '0;
            err  = '0;
         end
         en_prev = gate_en || rdlvl_en;
      end
   end

   task automatic tick();
      @(posedge SCLK);
      #1;
   endtask

   task automatic set_resp(input int dly);
      for (int i = 0; i < LANES; i++) delay[i] = dly;
      silent = '0;
      err_on = 1'b0;
      err_lanes = '0;
      err_in_rdlvl = 1'b0;
      err_rank = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      train_start = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      plog.delete();
   endtask

   // Leaves the bench in cycle t+1 where t is the cycle train_start was high.
   task automatic start_train(input logic [1:0] re, input logic [8:0] lm);
      rank_en = re;
      lane_mask = lm;
      train_start = 1'b1;
      tick();
      train_start = 1'b0;
   endtask

   task automatic wait_end(input int budget, input string name);
      int n;
      n = 0;
      while (!(train_done || train_fail) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!(train_done || train_fail)) begin
         errors++;
         $display("FAIL %s_end: no done/fail after %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      logic [21:0] obs;
      reset = 1'b1;
      train_start = 1'b0;
      rank_en = 2'b00;
      lane_mask = '0;
      timeout_limit = '0;
      set_resp(1);
      tick();
      obs = {gate_en, rdlvl_en, cs_0_n, cs_1_n, train_busy, train_done, train_fail,
             fail_timeout, fail_rank, fail_phase, retry_count, fail_lanes};
      checks++;
      if (obs !== 22'b0011_000_0_0_00_00_000000000) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b", obs, 22'b0011_000_0_0_00_00_000000000);
      end
      reset = 1'b0;
   endtask

   task automatic test_clean_latency();
      do_reset();
      set_resp(0);
      for (int i = 0; i < LANES; i++) delay[i] = i % 4;
      timeout_limit = TW'(1000);
      start_train(2'b11, 9'h1FF);
      checks++;
      if (cs_0_n !== 1'b1) begin errors++; $display("FAIL cs0_t1: got %b expected 1", cs_0_n); end
      tick();
      checks++;
      if ({cs_0_n, cs_1_n, train_busy} !== 3'b011) begin
         errors++;
         $display("FAIL cs_busy_t2: got %b expected 011", {cs_0_n, cs_1_n, train_busy});
      end
      repeat (S) tick();
      checks++;
      if (gate_en !== 1'b0) begin errors++; $display("FAIL gate_early: got %b expected 0", gate_en); end
      tick();
      checks++;
      if (gate_en !== 1'b1) begin errors++; $display("FAIL gate_rise: got %b expected 1", gate_en); end
      repeat (3) tick();
      checks++;
      if (gate_en !== 1'b1) begin errors++; $display("FAIL gate_hold: got %b expected 1", gate_en); end
      tick();
      checks++;
      if (gate_en !== 1'b0) begin errors++; $display("FAIL gate_drop: got %b expected 0", gate_en); end
      wait_end(2000, "clean");
      checks++;
      if ({train_done, train_fail, fail_lanes} !== {2'b10, 9'h000}) begin
         errors++;
         $display("FAIL clean_status: got done=%b fail=%b lanes=%h expected 1 0 000",
                  train_done, train_fail, fail_lanes);
      end
      checks++;
      if (plog.size() != 4) begin
         errors++;
         $display("FAIL clean_phase_count: got %0d expected 4", plog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (plog[i] != i) begin
               errors++;
               $display("FAIL clean_phase_order[%0d]: got %0d expected %0d", i, plog[i], i);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      start_train(2'b11, 9'h1FF);
      tick();
      checks++;
      if ({train_done, train_busy} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_restart: got done/busy %b expected 01", {train_done, train_busy});
      end
      wait_end(2000, "b2b");
      checks++;
      if (train_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", train_done); end
   endtask

   task automatic test_timeout();
      do_reset();
      set_resp(1);
      delay[4] = 200;
      timeout_limit = TW'(100);
      start_train(2'b01, 9'h1FF);
      wait_end(500, "timeout");
      checks++;
      if ({train_fail, train_done, fail_timeout, fail_phase, fail_rank} !== 6'b101_01_0) begin
         errors++;
         $display("FAIL timeout_status: got %b expected 101010",
                  {train_fail, train_done, fail_timeout, fail_phase, fail_rank});
      end
      checks++;
      if (fail_lanes !== 9'h010) begin
         errors++;
         $display("FAIL timeout_lanes: got %h expected 010", fail_lanes);
      end
   endtask

   task automatic test_timeout_boundary();
      do_reset();
      set_resp(0);
      delay[0] = 5;
      timeout_limit = TW'(6);
      start_train(2'b01, 9'h1FF);
      wait_end(500, "tmo_edge_ok");
      checks++;
      if ({train_done, fail_timeout} !== 2'b10) begin
         errors++;
         $display("FAIL tmo_edge_ok: got done/timeout %b expected 10", {train_done, fail_timeout});
      end
      do_reset();
      delay[0] = 6;
      start_train(2'b01, 9'h1FF);
      wait_end(500, "tmo_edge_late");
      checks++;
      if ({train_fail, fail_timeout, fail_phase, fail_lanes} !== {4'b1101, 9'h001}) begin
         errors++;
         $display("FAIL tmo_edge_late: got fail=%b tmo=%b phase=%b lanes=%h expected 1 1 01 001",
                  train_fail, fail_timeout, fail_phase, fail_lanes);
      end
   endtask

   task automatic test_lane_error();
      logic [1:0] exp_retry;
      int         exp_phases;
`ifdef RDLVL_SEQ_RETRY_EN
      exp_retry  = 2'd3;
      exp_phases = 10;
`else
      exp_retry  = 2'd0;
      exp_phases = 4;
`endif
      do_reset();
      set_resp(1);
      err_on = 1'b1;
      err_lanes = 9'h004;
      err_in_rdlvl = 1'b1;
      err_rank = 1'b1;
      timeout_limit = '0;
      start_train(2'b11, 9'h1FF);
      wait_end(5000, "lane_err");
      checks++;
      if ({train_fail, fail_rank, fail_phase, fail_timeout} !== 5'b11_10_0) begin
         errors++;
         $display("FAIL lane_err_status: got %b expected 11100",
                  {train_fail, fail_rank, fail_phase, fail_timeout});
      end
      checks++;
      if (fail_lanes !== 9'h004) begin
         errors++;
         $display("FAIL lane_err_lanes: got %h expected 004", fail_lanes);
      end
      checks++;
      if (retry_count !== exp_retry) begin
         errors++;
         $display("FAIL lane_err_retry: got %0d expected %0d", retry_count, exp_retry);
      end
      checks++;
      if (plog.size() != exp_phases) begin
         errors++;
         $display("FAIL lane_err_phases: got %0d expected %0d", plog.size(), exp_phases);
      end
   endtask

   task automatic test_mask();
      do_reset();
      set_resp(1);
      silent = 9'h100;
      timeout_limit = TW'(500);
      start_train(2'b11, 9'h0FF);
      wait_end(2000, "mask");
      checks++;
      if ({train_done, train_fail, fail_lanes} !== {2'b10, 9'h000}) begin
         errors++;
         $display("FAIL mask_status: got done=%b fail=%b lanes=%h expected 1 0 000",
                  train_done, train_fail, fail_lanes);
      end
   endtask

   task automatic test_cfg_fail();
      do_reset();
      set_resp(1);
      start_train(2'b00, 9'h1FF);
      checks++;
      if (train_fail !== 1'b0) begin errors++; $display("FAIL cfg_t1: got %b expected 0", train_fail); end
      tick();
      checks++;
      if ({train_fail, fail_phase, train_busy, cs_0_n, cs_1_n} !== 6'b1_00_0_11) begin
         errors++;
         $display("FAIL cfg_rank_t2: got %b expected 100011",
                  {train_fail, fail_phase, train_busy, cs_0_n, cs_1_n});
      end
      start_train(2'b11, 9'h000);
      tick();
      checks++;
      if ({train_fail, train_done, fail_phase} !== 4'b10_00) begin
         errors++;
         $display("FAIL cfg_mask_t2: got %b expected 1000", {train_fail, train_done, fail_phase});
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      set_resp(1);
      timeout_limit = '0;
      start_train(2'b01, 9'h1FF);
      n = 0;
      while (rdlvl_en !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (rdlvl_en !== 1'b1) begin
         errors++;
         $display("FAIL mid_reach_rdlvl: got %b expected 1", rdlvl_en);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({gate_en, rdlvl_en, cs_0_n, cs_1_n, train_busy} !== 5'b00110) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b expected 00110",
                  {gate_en, rdlvl_en, cs_0_n, cs_1_n, train_busy});
      end
      tick();
      start_train(2'b11, 9'h1FF);
      wait_end(2000, "mid_rerun");
      checks++;
      if ({train_done, train_fail, fail_lanes} !== {2'b10, 9'h000}) begin
         errors++;
         $display("FAIL mid_rerun_status: got done=%b fail=%b lanes=%h expected 1 0 000",
                  train_done, train_fail, fail_lanes);
      end
   endtask

   initial begin
      test_reset();
      test_clean_latency();
      test_back_to_back();
      test_timeout();
      test_timeout_boundary();
      test_lane_error();
      test_mask();
      test_cfg_fail();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
